led_status_scheduler: RTL

Shares the board's single status LED between several fault/status requesters. Each requester signals a blink code: N short pulses, then a fixed gap. The block arbitrates by fixed priority and sequences the pulses from a slow tick. With nothing pending, the LED shows an idle heartbeat. It sits between the shutdown controller's status flags and the LED pin, and replaces the free-running blinker on that pin.

---
 rtl/led_status_scheduler_pkg.sv | 24 ++
 rtl/led_status_scheduler_tick_gen.sv | 28 ++
 rtl/led_status_scheduler.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/led_status_scheduler_pkg.sv
// Shared definitions for the status-LED scheduler: FSM encoding, slot counts and a log2 helper.
package led_status_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    localparam int GAP_TICKS = 4;
    localparam int HB_TICKS  = 4;

    // Ceiling log2, never below 1 so that counters and indices keep at least one bit.
    function automatic int c_log2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/led_status_scheduler_tick_gen.sv
// Slot tick for the LED scheduler: a one-cycle strobe every max(1, CLK_HZ/TICK_HZ) clocks.
// Free-running counter-and-compare from reset; no backpressure.
module led_status_scheduler_tick_gen
    import led_status_scheduler_pkg::*;
#(
    parameter int CLK_HZ  = 24000000,
    parameter int TICK_HZ = 8
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int TDIV = (CLK_HZ / TICK_HZ > 1) ? (CLK_HZ / TICK_HZ) : 1;
    localparam int CW   = c_log2(TDIV);
    localparam logic [CW-1:0] LAST = CW'(TDIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick  = (cnt_q == LAST);
    assign cnt_d = tick ? '0 : cnt_q + CW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/led_status_scheduler.sv
// Fixed-priority blink-code scheduler for the single status LED; outputs registered, one clock after the deciding tick.
// Requests are levels with no backpressure; bursts are non-preemptive. LED_SCHED_HEARTBEAT_EN adds the idle heartbeat.
module led_status_scheduler
    import led_status_scheduler_pkg::*;
#(
    parameter int CLK_HZ  = 24000000,
    parameter int TICK_HZ = 8,
    parameter int NREQ    = 4,
    parameter int CODE_W  = 3,
    localparam int ID_W   = c_log2(NREQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*CODE_W-1:0]   code,
    output logic                     led,
    output logic                     busy,
    output logic [ID_W-1:0]          active_id,
    output logic                     done
);

    localparam int GW = c_log2(GAP_TICKS);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TICKS - 1);

    logic tick;

    led_status_scheduler_tick_gen #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Priority encoder: lowest set index wins; a zero code is served as a single pulse.
    logic              req_any;
    logic [ID_W-1:0]   win_id;
    logic [CODE_W-1:0] win_code;

    always_comb begin
        win_id   = '0;
        win_code = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_id   = ID_W'(i);
                win_code = code[i*CODE_W +: CODE_W];
            end
        end
        if (win_code == '0) win_code = CODE_W'(1);
    end

    assign req_any = |req;

    state_t            state_q, state_d;
    logic [CODE_W-1:0] rem_q, rem_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic              gap_end;
    logic              led_q, led_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              idle_led;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            gap_q   <= '0;
            id_q    <= '0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            gap_q   <= gap_d;
            id_q    <= id_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        gap_d   = gap_q;
        id_d    = id_q;
        gap_end = 1'b0;
        if (!enable) begin
            state_d = ST_IDLE;
            gap_d   = '0;
        end else if (tick) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (req_any) begin
                        state_d = ST_ON;
                        rem_d   = win_code;
                        id_d    = win_id;
                    end
                end
                ST_ON: state_d = ST_OFF;
                ST_OFF: begin
                    rem_d   = rem_q - CODE_W'(1);
                    gap_d   = '0;
                    state_d = (rem_d != '0) ? ST_ON : ST_GAP;
                end
                ST_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        gap_end = 1'b1;
                        gap_d   = '0;
                        // Back-to-back service: a pending request skips IDLE entirely.
                        if (req_any) begin
                            state_d = ST_ON;
                            rem_d   = win_code;
                            id_d    = win_id;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        gap_d = gap_q + GW'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

`ifdef LED_SCHED_HEARTBEAT_EN
    localparam int HW = c_log2(HB_TICKS);
    localparam logic [HW-1:0] HB_LAST = HW'(HB_TICKS - 1);

    logic [HW-1:0] hb_cnt_q, hb_cnt_d;
    logic          hb_led_q, hb_led_d;

    // Phase only advances on ticks spent resting in IDLE; leaving or entering a burst freezes it.
    always_comb begin
        hb_cnt_d = hb_cnt_q;
        hb_led_d = hb_led_q;
        if (!enable) begin
            hb_cnt_d = '0;
            hb_led_d = 1'b0;
        end else if (tick && state_q == ST_IDLE && state_d == ST_IDLE) begin
            if (hb_cnt_q == HB_LAST) begin
                hb_cnt_d = '0;
                hb_led_d = ~hb_led_q;
            end else begin
                hb_cnt_d = hb_cnt_q + HW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hb_cnt_q <= '0;
            hb_led_q <= 1'b0;
        end else begin
            hb_cnt_q <= hb_cnt_d;
            hb_led_q <= hb_led_d;
        end
    end

    assign idle_led = hb_led_d;
`else
    assign idle_led = 1'b0;
`endif

    always_comb begin
        led_d  = 1'b0;
        busy_d = (state_d != ST_IDLE);
        done_d = gap_end;
        unique case (state_d)
            ST_ON:   led_d = 1'b1;
            ST_IDLE: led_d = enable & idle_led;
            default: led_d = 1'b0;
        endcase
    end

    assign led       = led_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign active_id = id_q;

endmodule
